// File: rtl/dvp_capture_if.sv
// Pixel word stream between the DVP capture block and the frame-buffer writer.
// pix_sof / pix_eol qualify pix_data and are meaningful only while pix_valid is high.
interface dvp_capture_if;
    logic [31:0] pix_data;
    logic        pix_valid;
    logic        pix_ready;
    logic        pix_sof;
    logic        pix_eol;

    modport master (
        output pix_data,
        output pix_valid,
        output pix_sof,
        output pix_eol,
        input  pix_ready
    );

    modport slave (
        input  pix_data,
        input  pix_valid,
        input  pix_sof,
        input  pix_eol,
        output pix_ready
    );
endinterface

// File: rtl/dvp_capture.sv
// DVP camera receiver: samples pins, packs byte pairs into pixels, pixel pairs into
// words, and buffers words in a small FIFO with per-frame geometry and error reporting.
module dvp_capture #(
    parameter int FIFO_DEPTH = 4,
    parameter int EXP_WIDTH  = 100,
    parameter int EXP_HEIGHT = 70
) (
    input  logic          cam_pclk,
    input  logic          cam_rst,
    input  logic          cap_en,
    input  logic          err_clr,
    input  logic          cam_vsync,
    input  logic          cam_href,
    input  logic [7:0]    cam_data,
    dvp_capture_if.master pix_if,
    output logic          frame_done,
    output logic [15:0]   frame_lines,
    output logic [15:0]   frame_pixels,
    output logic          ovf_err,
    output logic          odd_err,
    output logic          size_err
);

    localparam int          AW = $clog2(FIFO_DEPTH);
    localparam logic [15:0] EW = 16'(EXP_WIDTH);
    localparam logic [15:0] EH = 16'(EXP_HEIGHT);

    typedef enum logic [1:0] {IDLE, SYNC, WAIT, LINE} state_t;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    state_t      state_q, state_d;
    logic        vs_q, vsp_q, hr_q;
    logic [7:0]  dat_q;
    logic        bt_q, bt_d;
    logic [7:0]  hb_q, hb_d;
    logic        p0v_q, p0v_d;
    logic [15:0] p0_q, p0_d;
    logic        hv_q, hv_d;
    logic [31:0] hw_q, hw_d;
    logic [15:0] px_q, px_d;
    logic [15:0] ln_q, ln_d;
    logic        bad_q, bad_d;
    logic        sofp_q, sofp_d;
    logic        fdone_q, fdone_d;
    logic [15:0] flines_q, flines_d;
    logic [15:0] fpix_q, fpix_d;
    logic        ovf_q, odd_q, size_q;

    logic        vs_rise, vs_fall;
    logic        byte_en, line_start, line_end, frame_end;
    logic        odd_ev, size_ev, sof_set;
    logic        push, push_eol;
    logic [31:0] push_w;
    logic [15:0] pix_w;

    logic [AW:0] wr_q, rd_q;
    logic [33:0] mem_q [FIFO_DEPTH];
    logic [33:0] head;
    logic        empty, full, pop, do_push, ovf_ev;

    assign vs_rise = vs_q & ~vsp_q;
    assign vs_fall = ~vs_q & vsp_q;

    always_comb begin
        state_d    = state_q;
        bt_d       = bt_q;
        hb_d       = hb_q;
        p0v_d      = p0v_q;
        p0_d       = p0_q;
        hv_d       = hv_q;
        hw_d       = hw_q;
        px_d       = px_q;
        ln_d       = ln_q;
        bad_d      = bad_q;
        sofp_d     = sofp_q;
        fdone_d    = 1'b0;
        flines_d   = flines_q;
        fpix_d     = fpix_q;
        byte_en    = 1'b0;
        line_start = 1'b0;
        line_end   = 1'b0;
        frame_end  = 1'b0;
        odd_ev     = 1'b0;
        size_ev    = 1'b0;
        sof_set    = 1'b0;
        push       = 1'b0;
        push_eol   = 1'b0;
        push_w     = '0;
        pix_w      = '0;

        unique case (state_q)
            IDLE: begin
                if (vs_rise && cap_en) state_d = SYNC;
            end
            SYNC: begin
                if (vs_fall) begin
                    state_d = WAIT;
                    sof_set = 1'b1;
                end
            end
            WAIT: begin
                if (vs_rise) begin
                    frame_end = 1'b1;
                    state_d   = cap_en ? SYNC : IDLE;
                end else if (hr_q) begin
                    state_d    = LINE;
                    byte_en    = 1'b1;
                    line_start = 1'b1;
                end
            end
            LINE: begin
                if (vs_rise) begin
                    line_end  = 1'b1;
                    frame_end = 1'b1;
                    odd_ev    = 1'b1;
                    state_d   = SYNC;
                end else if (!hr_q) begin
                    line_end = 1'b1;
                    odd_ev   = bt_q;
                    state_d  = WAIT;
                end else begin
                    byte_en = 1'b1;
                end
            end
        endcase

        // A completed pixel 0 proves the held word is not the last of its line.
        if (byte_en) begin
            if (line_start || !bt_q) begin
                hb_d = dat_q;
                bt_d = 1'b1;
                if (line_start) px_d = '0;
            end else begin
                bt_d  = 1'b0;
                px_d  = sat_inc(px_q);
                pix_w = {hb_q, dat_q};
                if (!p0v_q) begin
                    p0_d  = pix_w;
                    p0v_d = 1'b1;
                    if (hv_q) begin
                        push   = 1'b1;
                        push_w = hw_q;
                        hv_d   = 1'b0;
                    end
                end else begin
                    hw_d  = {pix_w, p0_q};
                    hv_d  = 1'b1;
                    p0v_d = 1'b0;
                end
            end
        end

        if (line_end) begin
            if (p0v_q && !frame_end) begin
                push     = 1'b1;
                push_eol = 1'b1;
                push_w   = {16'h0, p0_q};
            end else if (hv_q) begin
                push     = 1'b1;
                push_eol = 1'b1;
                push_w   = hw_q;
            end
            p0v_d = 1'b0;
            hv_d  = 1'b0;
            bt_d  = 1'b0;
            ln_d  = sat_inc(ln_q);
            bad_d = bad_q | (px_q != EW);
        end

        if (frame_end) begin
            if (ln_d != 16'd0) begin
                fdone_d  = 1'b1;
                flines_d = ln_d;
                fpix_d   = px_q;
                size_ev  = (ln_d != EH) | bad_d;
            end
            ln_d  = '0;
            bad_d = 1'b0;
        end

        if (push) sofp_d = 1'b0;
        if (sof_set) sofp_d = 1'b1;
    end

    assign empty   = (wr_q == rd_q);
    assign full    = (wr_q[AW] != rd_q[AW]) &&
                     (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign pop     = ~empty & pix_if.pix_ready;
    assign do_push = push & (~full | pop);
    assign ovf_ev  = push & full & ~pop;
    assign head    = mem_q[rd_q[AW-1:0]];

    always_ff @(posedge cam_pclk or posedge cam_rst) begin
        if (cam_rst) begin
            state_q  <= IDLE;
            vs_q     <= 1'b0;
            vsp_q    <= 1'b0;
            hr_q     <= 1'b0;
            dat_q    <= '0;
            bt_q     <= 1'b0;
            hb_q     <= '0;
            p0v_q    <= 1'b0;
            p0_q     <= '0;
            hv_q     <= 1'b0;
            hw_q     <= '0;
            px_q     <= '0;
            ln_q     <= '0;
            bad_q    <= 1'b0;
            sofp_q   <= 1'b0;
            fdone_q  <= 1'b0;
            flines_q <= '0;
            fpix_q   <= '0;
            ovf_q    <= 1'b0;
            odd_q    <= 1'b0;
            size_q   <= 1'b0;
            wr_q     <= '0;
            rd_q     <= '0;
        end else begin
            state_q  <= state_d;
            vs_q     <= cam_vsync;
            vsp_q    <= vs_q;
            hr_q     <= cam_href;
            dat_q    <= cam_data;
            bt_q     <= bt_d;
            hb_q     <= hb_d;
            p0v_q    <= p0v_d;
            p0_q     <= p0_d;
            hv_q     <= hv_d;
            hw_q     <= hw_d;
            px_q     <= px_d;
            ln_q     <= ln_d;
            bad_q    <= bad_d;
            sofp_q   <= sofp_d;
            fdone_q  <= fdone_d;
            flines_q <= flines_d;
            fpix_q   <= fpix_d;
            ovf_q    <= (ovf_q & ~err_clr) | ovf_ev;
            odd_q    <= (odd_q & ~err_clr) | odd_ev;
            size_q   <= (size_q & ~err_clr) | size_ev;
            if (do_push) wr_q <= wr_q + 1'b1;
            if (pop) rd_q <= rd_q + 1'b1;
        end
    end

    always_ff @(posedge cam_pclk) begin
        if (do_push) mem_q[wr_q[AW-1:0]] <= {sofp_q, push_eol, push_w};
    end

    assign pix_if.pix_valid = ~empty;
    assign pix_if.pix_data  = empty ? 32'h0 : head[31:0];
    assign pix_if.pix_eol   = ~empty & head[32];
    assign pix_if.pix_sof   = ~empty & head[33];
    assign frame_done       = fdone_q;
    assign frame_lines      = flines_q;
    assign frame_pixels     = fpix_q;
    assign ovf_err          = ovf_q;
    assign odd_err          = odd_q;
    assign size_err         = size_q;

endmodule

// File: tb/tb_dvp_capture.sv
// Randomized bench for dvp_capture: byte lines are driven on the falling edge and
// accepted words are compared against a pixel-pairing reference model.
module tb_dvp_capture;

    logic        clk = 1'b0;
    logic        rst;
    logic        cap_en, err_clr, vs, hr;
    logic [7:0]  dat;
    logic        frame_done, ovf_err, odd_err, size_err;
    logic [15:0] frame_lines, frame_pixels;

    dvp_capture_if bus ();

    dvp_capture dut (
        .cam_pclk     (clk),
        .cam_rst      (rst),
        .cap_en       (cap_en),
        .err_clr      (err_clr),
        .cam_vsync    (vs),
        .cam_href     (hr),
        .cam_data     (dat),
        .pix_if       (bus),
        .frame_done   (frame_done),
        .frame_lines  (frame_lines),
        .frame_pixels (frame_pixels),
        .ovf_err      (ovf_err),
        .odd_err      (odd_err),
        .size_err     (size_err)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [33:0] got_q[$];
    logic [33:0] exp_q[$];
    logic [7:0]  lb[$];
    bit          m_sof = 1'b0;
    int          fd_cnt = 0;
    int          fd0, e, s;
    logic [15:0] fd_lines, fd_pix;

    task automatic check(input string tag, input logic [31:0] got_v,
                         input logic [31:0] exp_v);
        checks++;
        if (got_v !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got_v, exp_v);
        end
    endtask

    always @(negedge clk) begin
        #1;
        if (!rst) begin
            if (bus.pix_valid && bus.pix_ready)
                got_q.push_back({bus.pix_sof, bus.pix_eol, bus.pix_data});
            if (frame_done) begin
                fd_cnt++;
                fd_lines = frame_lines;
                fd_pix   = frame_pixels;
            end
        end
    end

    // Pixels are byte pairs {first, second}; words are pixel pairs {p1, p0}.
    task automatic model_line();
        int np, nw;
        logic [15:0] px[$];
        np = lb.size() / 2;
        nw = (np + 1) / 2;
        for (int i = 0; i < np; i++) px.push_back({lb[2*i], lb[2*i+1]});
        for (int w = 0; w < nw; w++) begin
            logic [15:0] hi;
            logic        eol;
            hi  = (2*w + 1 < np) ? px[2*w+1] : 16'h0;
            eol = (w == nw - 1);
            exp_q.push_back({m_sof, eol, hi, px[2*w]});
            m_sof = 1'b0;
        end
    endtask

    task automatic rand_line(input int n);
        lb.delete();
        repeat (n) lb.push_back(8'($urandom));
    endtask

    task automatic send_line(input bit model);
        foreach (lb[i]) begin
            @(negedge clk);
            hr  = 1'b1;
            dat = lb[i];
        end
        @(negedge clk);
        hr  = 1'b0;
        dat = 8'h0;
        repeat (8) @(negedge clk);
        if (model) model_line();
    endtask

    task automatic vsync_pulse();
        @(negedge clk);
        vs = 1'b1;
        repeat (4) @(negedge clk);
        vs = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic err_clr_pulse();
        @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while (bus.pix_valid && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("drain_timeout", 32'(t < 200), 32'd1);
        repeat (2) @(negedge clk);
    endtask

    task automatic compare_stream(input string tag, output int eols,
                                  output int sofs);
        int mis;
        mis  = 0;
        eols = 0;
        sofs = 0;
        check({tag, "_n"}, got_q.size(), exp_q.size());
        foreach (got_q[i]) begin
            if (i >= exp_q.size() || got_q[i] !== exp_q[i]) mis++;
            eols += int'(got_q[i][32]);
            sofs += int'(got_q[i][33]);
        end
        check({tag, "_data"}, mis, 0);
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        cap_en = 1'b0;
        err_clr = 1'b0;
        vs = 1'b0;
        hr = 1'b0;
        dat = 8'h0;
        bus.pix_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("rst_valid", 32'(bus.pix_valid), 32'd0);
        check("rst_data", bus.pix_data, 32'd0);
        check("rst_lines", 32'(frame_lines), 32'd0);
        check("rst_err", 32'({frame_done, ovf_err, odd_err, size_err}), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        cap_en = 1'b1;
        vsync_pulse();
        m_sof = 1'b1;
        repeat (70) begin
            rand_line(200);
            send_line(1'b1);
        end
        fd0 = fd_cnt;
        vsync_pulse();
        m_sof = 1'b1;
        compare_stream("frame1", e, s);
        check("f1_eol", e, 70);
        check("f1_sof", s, 1);
        check("f1_done", fd_cnt - fd0, 1);
        check("f1_lines", 32'(fd_lines), 32'd70);
        check("f1_pix", 32'(fd_pix), 32'd100);
        check("f1_err", 32'({ovf_err, odd_err, size_err}), 32'd0);

        lb.delete();
        lb.push_back(8'h12); lb.push_back(8'h34);
        lb.push_back(8'h56); lb.push_back(8'h78);
        send_line(1'b1);
        lb.delete();
        lb.push_back(8'h12); lb.push_back(8'h34);
        send_line(1'b1);
        check("w4_data", got_q[0][31:0], 32'h5678_1234);
        check("w4_eol", 32'(got_q[0][32]), 32'd1);
        check("w2_data", got_q[1][31:0], 32'h0000_1234);
        check("w2_eol", 32'(got_q[1][32]), 32'd1);
        compare_stream("short", e, s);
        check("short_sof", s, 1);
        rand_line(201);
        send_line(1'b1);
        check("odd_n", got_q.size(), 50);
        check("odd_last_eol", 32'(got_q[49][32]), 32'd1);
        compare_stream("odd", e, s);
        check("odd_eols", e, 1);
        check("odd_set", 32'(odd_err), 32'd1);
        err_clr_pulse();
        check("odd_clr", 32'(odd_err), 32'd0);
        fd0 = fd_cnt;
        vsync_pulse();
        m_sof = 1'b1;
        check("f2_done", fd_cnt - fd0, 1);
        check("f2_lines", 32'(fd_lines), 32'd3);
        check("f2_pix", 32'(fd_pix), 32'd100);
        check("f2_size", 32'(size_err), 32'd1);
        err_clr_pulse();

        bus.pix_ready = 1'b0;
        rand_line(40);
        send_line(1'b1);
        while (exp_q.size() > 4) void'(exp_q.pop_back());
        check("ovf_set", 32'(ovf_err), 32'd1);
        check("ovf_held", got_q.size(), 0);
        @(negedge clk);
        bus.pix_ready = 1'b1;
        wait_drain();
        compare_stream("ovf", e, s);
        check("ovf_sof", s, 1);

        vsync_pulse();
        m_sof = 1'b1;
        err_clr_pulse();
        check("f4_clr", 32'({ovf_err, odd_err, size_err}), 32'd0);
        repeat (69) begin
            rand_line(200);
            send_line(1'b1);
        end
        cap_en = 1'b0;
        fd0 = fd_cnt;
        vsync_pulse();
        compare_stream("frame4", e, s);
        check("f4_eol", e, 69);
        check("f4_done", fd_cnt - fd0, 1);
        check("f4_lines", 32'(fd_lines), 32'd69);
        check("f4_pix", 32'(fd_pix), 32'd100);
        check("f4_size", 32'(size_err), 32'd1);
        rand_line(20);
        send_line(1'b0);
        vsync_pulse();
        send_line(1'b0);
        check("idle_words", got_q.size(), 0);

        bus.pix_ready = 1'b0;
        cap_en = 1'b1;
        vsync_pulse();
        rand_line(40);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            hr  = 1'b1;
            dat = lb[i];
        end
        check("pre_rst_valid", 32'(bus.pix_valid), 32'd1);
        check("pre_rst_lines", 32'(frame_lines), 32'd69);
        #2 rst = 1'b1;
        #1;
        check("rst_async_valid", 32'(bus.pix_valid), 32'd0);
        check("rst_async_data", bus.pix_data, 32'd0);
        check("rst_async_lines", 32'(frame_lines), 32'd0);
        check("rst_async_pix", 32'(frame_pixels), 32'd0);
        check("rst_async_err", 32'({ovf_err, odd_err, size_err}), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 20; i < 40; i++) begin
            @(negedge clk);
            hr  = 1'b1;
            dat = lb[i];
        end
        @(negedge clk);
        hr = 1'b0;
        bus.pix_ready = 1'b1;
        repeat (4) @(negedge clk);
        rand_line(16);
        send_line(1'b0);
        check("post_rst_words", got_q.size(), 0);
        vsync_pulse();
        m_sof = 1'b1;
        rand_line(8);
        send_line(1'b1);
        wait_drain();
        compare_stream("restart", e, s);
        check("restart_sof", s, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
